// File: rtl/reg_value1_pkg.sv
// Shared pipeline definitions for operand forwarding.
// ForwardSel1 encodings that identify where a forwarded operand came from.
package reg_value1_pkg;

  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_PRI  = 2'd1,
    SEL_HIST = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/reg_value1_match.sv
// Index comparator for forwarding: hit on a valid write to the index being read.
// Register 0 is hard-wired, so it never produces a hit.
module regvalue_match #(
  parameter int ADDR_W = 5
) (
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_wrIdx,
  input  logic [ADDR_W-1:0] i_rdIdx,
  output logic              o_hit
);

  assign o_hit = i_valid && (i_wrIdx == i_rdIdx) && (i_rdIdx != '0);

endmodule

// File: rtl/reg_value1.sv
// Register operand forwarding: primary pending write, optional one-deep write history.
// History path is built only when REGVALUE1_HISTORY_EN is defined.
module reg_value1
  import reg_value1_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [DATA_W-1:0] RegisterData1,
  input  logic [ADDR_W-1:0] WriteRegister1stPri1,
  input  logic [DATA_W-1:0] WriteData1stPri1,
  input  logic              Valid1stPri1,
  input  logic              comment,
  output logic [DATA_W-1:0] Output1,
  output logic [1:0]        ForwardSel1
);

  logic              w_priHit;
  logic              w_histHit;
  logic [DATA_W-1:0] w_histData;
  logic              w_unused;

  regvalue_match #(.ADDR_W(ADDR_W)) u_priMatch (
    .i_valid (Valid1stPri1),
    .i_wrIdx (WriteRegister1stPri1),
    .i_rdIdx (ReadRegister1),
    .o_hit   (w_priHit)
  );

`ifdef REGVALUE1_HISTORY_EN
  logic              r_histValid;
  logic [ADDR_W-1:0] r_histIdx;
  logic [DATA_W-1:0] r_histData;

  // Last cycle's primary write, kept so a just-retired result still forwards.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_histValid <= 1'b0;
      r_histIdx   <= '0;
      r_histData  <= '0;
    end else begin
      r_histValid <= Valid1stPri1;
      r_histIdx   <= WriteRegister1stPri1;
      r_histData  <= WriteData1stPri1;
    end
  end

  regvalue_match #(.ADDR_W(ADDR_W)) u_histMatch (
    .i_valid (r_histValid),
    .i_wrIdx (r_histIdx),
    .i_rdIdx (ReadRegister1),
    .o_hit   (w_histHit)
  );

  assign w_histData = r_histData;
  assign w_unused   = comment;
`else
  assign w_histHit  = 1'b0;
  assign w_histData = '0;
  assign w_unused   = &{1'b0, CLK, RESET, comment};
`endif

  // The primary write is the youngest value, so it wins over history.
  always_comb begin
    Output1     = RegisterData1;
    ForwardSel1 = SEL_REG;
    if (w_priHit) begin
      Output1     = WriteData1stPri1;
      ForwardSel1 = SEL_PRI;
    end else if (w_histHit) begin
      Output1     = w_histData;
      ForwardSel1 = SEL_HIST;
    end
  end

endmodule

// File: tb/tb_reg_value1.sv
// Directed-vector testbench for reg_value1; history checks adapt to REGVALUE1_HISTORY_EN.
module tb_reg_value1;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGVALUE1_HISTORY_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic              CLK;
  logic              RESET;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [DATA_W-1:0] RegisterData1;
  logic [ADDR_W-1:0] WriteRegister1stPri1;
  logic [DATA_W-1:0] WriteData1stPri1;
  logic              Valid1stPri1;
  logic              comment;
  logic [DATA_W-1:0] Output1;
  logic [1:0]        ForwardSel1;

  int testsRun;
  int testsFailed;

  reg_value1 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .ReadRegister1        (ReadRegister1),
    .RegisterData1        (RegisterData1),
    .WriteRegister1stPri1 (WriteRegister1stPri1),
    .WriteData1stPri1     (WriteData1stPri1),
    .Valid1stPri1         (Valid1stPri1),
    .comment              (comment),
    .Output1              (Output1),
    .ForwardSel1          (ForwardSel1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one input vector and let the combinational path settle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] rdData,
                               input logic v, input logic [ADDR_W-1:0] wr,
                               input logic [DATA_W-1:0] wrData);
    ReadRegister1        = rd;
    RegisterData1        = rdData;
    Valid1stPri1         = v;
    WriteRegister1stPri1 = wr;
    WriteData1stPri1     = wrData;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    comment     = 1'b0;
    RESET       = 1'b1;
    applyStimulus(5'd3, 32'hAAAA0000, 1'b0, 5'd0, 32'h0);
    checkOutput("reset_out", 64'(Output1), 64'h0000_0000_AAAA_0000);
    checkOutput("reset_sel", 64'(ForwardSel1), 64'd0);

    // Combinational vectors while history is held clear by reset.
    applyStimulus(5'd5, 32'h11111111, 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("pri_hit_out", 64'(Output1), 64'hDEADBEEF);
    checkOutput("pri_hit_sel", 64'(ForwardSel1), 64'd1);
    applyStimulus(5'd5, 32'h11111111, 1'b0, 5'd5, 32'hDEADBEEF);
    checkOutput("pri_invalid_out", 64'(Output1), 64'h11111111);
    checkOutput("pri_invalid_sel", 64'(ForwardSel1), 64'd0);
    applyStimulus(5'd0, 32'h0BADF00D, 1'b1, 5'd0, 32'h12345678);
    checkOutput("reg0_out", 64'(Output1), 64'h0BADF00D);
    checkOutput("reg0_sel", 64'(ForwardSel1), 64'd0);
    applyStimulus(5'd6, 32'h66666666, 1'b1, 5'd5, 32'h55555555);
    checkOutput("idx_miss_out", 64'(Output1), 64'h66666666);
    checkOutput("idx_miss_sel", 64'(ForwardSel1), 64'd0);
    applyStimulus(5'd31, 32'h1F1F1F1F, 1'b1, 5'd31, 32'hFFFF0031);
    checkOutput("reg31_out", 64'(Output1), 64'hFFFF0031);

    @(negedge CLK);
    RESET = 1'b0;

    // Write reg 7; read of a different register must not forward.
    applyStimulus(5'd3, 32'h33333333, 1'b1, 5'd7, 32'hCAFE0001);
    checkOutput("hist_load_out", 64'(Output1), 64'h33333333);
    @(negedge CLK);
    applyStimulus(5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0);
    checkOutput("hist_hit_out", 64'(Output1), HIST ? 64'hCAFE0001 : 64'h77777777);
    checkOutput("hist_hit_sel", 64'(ForwardSel1), HIST ? 64'd2 : 64'd0);

    // Primary beats history on the same index.
    applyStimulus(5'd7, 32'h77777777, 1'b1, 5'd7, 32'hA);
    @(negedge CLK);
    applyStimulus(5'd7, 32'h77777777, 1'b1, 5'd7, 32'hB);
    checkOutput("pri_over_hist_out", 64'(Output1), 64'hB);
    checkOutput("pri_over_hist_sel", 64'(ForwardSel1), 64'd1);
    @(negedge CLK);
    applyStimulus(5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0);
    checkOutput("hist_latest_out", 64'(Output1), HIST ? 64'hB : 64'h77777777);
    applyStimulus(5'd6, 32'h66666666, 1'b0, 5'd0, 32'h0);
    checkOutput("hist_idx_miss_sel", 64'(ForwardSel1), 64'd0);

    // Invalid writes are captured as invalid and never forward.
    @(negedge CLK);
    applyStimulus(5'd7, 32'h70707070, 1'b0, 5'd0, 32'h0);
    checkOutput("hist_invalid_out", 64'(Output1), 64'h70707070);
    checkOutput("hist_invalid_sel", 64'(ForwardSel1), 64'd0);

    // A captured write to register 0 never hits.
    applyStimulus(5'd0, 32'h00C0FFEE, 1'b1, 5'd0, 32'h12345678);
    @(negedge CLK);
    applyStimulus(5'd0, 32'h00C0FFEE, 1'b0, 5'd0, 32'h0);
    checkOutput("hist_reg0_out", 64'(Output1), 64'h00C0FFEE);
    checkOutput("hist_reg0_sel", 64'(ForwardSel1), 64'd0);

    // Reset asserted between clocks clears history at once.
    applyStimulus(5'd7, 32'h77777777, 1'b1, 5'd7, 32'hCAFE0002);
    @(posedge CLK);
    #2;
    applyStimulus(5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0);
    checkOutput("pre_reset_out", 64'(Output1), HIST ? 64'hCAFE0002 : 64'h77777777);
    RESET = 1'b1;
    #1;
    checkOutput("async_reset_out", 64'(Output1), 64'h77777777);
    checkOutput("async_reset_sel", 64'(ForwardSel1), 64'd0);

    // Capture resumes on the first clock after reset releases.
    @(negedge CLK);
    RESET = 1'b0;
    applyStimulus(5'd2, 32'h22222222, 1'b1, 5'd9, 32'h99999999);
    @(negedge CLK);
    applyStimulus(5'd9, 32'h09090909, 1'b0, 5'd0, 32'h0);
    checkOutput("resume_out", 64'(Output1), HIST ? 64'h99999999 : 64'h09090909);
    checkOutput("resume_sel", 64'(ForwardSel1), HIST ? 64'd2 : 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
